cam_frame_wr_ctrl: RTL and testbench



---
 rtl/cam_axi_pkg.sv | 21 ++
 rtl/cam_frame_wr_ctrl_if.sv | 38 +++
 rtl/cam_buf_ring.sv | 53 +++++
 rtl/cam_frame_wr_ctrl.sv | 166 ++++++++++++++++
 tb/tb_cam_frame_wr_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cam_axi_pkg.sv
// Shared types and AXI constants for the camera frame write controller.
package cam_axi_pkg;

    // Write-controller FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_AW,
        ST_W,
        ST_B
    } wr_state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // AXI AxSIZE encoding for a full-width beat
    function automatic logic [2:0] axi_size(input int data_width);
        return 3'($clog2(data_width / 8));
    endfunction

endpackage

// File: rtl/cam_frame_wr_ctrl_if.sv
// AXI4 write-channel bundle (AW/W/B) between the frame writer and the interconnect.
interface cam_frame_wr_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/cam_buf_ring.sv
// Frame buffer ring: current/last buffer index and the current buffer's base address.
// With CAM_BUF_LOCK_EN defined, the buffer held by the reader is skipped on advance.
module cam_buf_ring #(
    parameter int                    ADDR_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE    = ADDR_WIDTH'(32'h0010_0000),
    parameter int                    NUM_FRAME_BUF = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
`ifdef CAM_BUF_LOCK_EN
    input  logic                  rd_lock_valid,
    input  logic [2:0]            rd_lock_idx,
`endif
    output logic [2:0]            buf_idx,
    output logic [2:0]            last_buf_idx,
    output logic [ADDR_WIDTH-1:0] buf_base
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_FRAME_BUF - 1);

    logic [2:0] next_idx;

    function automatic logic [2:0] wrap_inc(input logic [2:0] idx);
        return (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    endfunction

    // Pick the buffer the next frame goes to
    always_comb begin
        // NOTE: assigning a default before any conditional keeps this combinational (no latch).
        next_idx = wrap_inc(buf_idx);
`ifdef CAM_BUF_LOCK_EN
        if (NUM_FRAME_BUF > 1 && rd_lock_valid && next_idx == rd_lock_idx)
            next_idx = wrap_inc(next_idx);
`endif
    end

    // Rotate the ring when a frame completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_idx      <= 3'd0;
            last_buf_idx <= LAST_IDX;
        end else if (advance) begin
            // NOTE: non-blocking so last_buf_idx captures the pre-advance buf_idx.
            last_buf_idx <= buf_idx;
            buf_idx      <= next_idx;
        end
    end

    assign buf_base = BASE_ADDR + ADDR_WIDTH'(buf_idx) * BUF_STRIDE;

endmodule

// File: rtl/cam_frame_wr_ctrl.sv
// Camera frame AXI4 write-burst master: drains an FWFT pixel FIFO into a ring of
// DDR frame buffers using fixed INCR bursts with a shortened final burst.
// Optional feature macro: CAM_BUF_LOCK_EN (reader buffer lock, skips a locked buffer).
module cam_frame_wr_ctrl
    import cam_axi_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = ADDR_WIDTH'(32'h1000_0000),
    parameter logic [ADDR_WIDTH-1:0] BUF_STRIDE    = ADDR_WIDTH'(32'h0010_0000),
    parameter int                    NUM_FRAME_BUF = 3,
    parameter int                    FRAME_WORDS   = 153600,
    parameter int                    BURST_LEN     = 128,
    parameter int                    CNT_WIDTH     = 11
) (
    input  logic                  m00_axi_aclk,
    input  logic                  m00_axi_asy_rst,
    input  logic                  frame_start,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    input  logic [CNT_WIDTH-1:0]  fifo_rd_data_count,
    output logic                  fifo_rd_en,
`ifdef CAM_BUF_LOCK_EN
    input  logic                  rd_lock_valid,
    input  logic [2:0]            rd_lock_idx,
`endif
    cam_frame_wr_ctrl_if.master   m00_axi,
    output logic                  frame_done,
    output logic [2:0]            last_buf_idx,
    output logic                  busy,
    output logic                  wr_error,
    output logic                  frame_overrun
);

    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
    localparam logic [ADDR_WIDTH-1:0] BYTES_PER_WORD = ADDR_WIDTH'(DATA_WIDTH / 8);

    wr_state_t             state, state_nxt;
    logic [CW-1:0]         remaining, offset;
    logic [BW-1:0]         beats, beat_cnt;
    logic [ADDR_WIDTH-1:0] awaddr_q, buf_base;
    logic [7:0]            awlen_q;
    logic [2:0]            buf_idx;
    logic                  frame_done_q, busy_q, wr_error_q, overrun_q;
    logic                  awvalid_c, wvalid_c, bready_c;
    logic                  data_ready, w_hs, last_beat, last_burst, advance;

    // Size of the current burst and readiness of the FIFO to feed it without stalling
    always_comb begin
        beats      = (32'(remaining) < 32'(BURST_LEN)) ? BW'(remaining) : BW'(BURST_LEN);
        data_ready = 32'(fifo_rd_data_count) >= 32'(beats);
        last_beat  = (beat_cnt == beats - BW'(1));
        last_burst = (32'(remaining) == 32'(beats));
    end

    // State register
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_asy_rst) begin
        if (m00_axi_asy_rst) state <= ST_IDLE;
        else                 state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        awvalid_c = 1'b0;
        wvalid_c  = 1'b0;
        bready_c  = 1'b0;
        case (state)
            ST_IDLE:      if (frame_start) state_nxt = ST_WAIT_DATA;
            ST_WAIT_DATA: if (data_ready) state_nxt = ST_AW;
            ST_AW: begin
                awvalid_c = 1'b1;
                if (m00_axi.awready) state_nxt = ST_W;
            end
            ST_W: begin
                wvalid_c = ~fifo_empty;
                if (wvalid_c && m00_axi.wready && last_beat) state_nxt = ST_B;
            end
            ST_B: begin
                bready_c = 1'b1;
                if (m00_axi.bvalid) state_nxt = last_burst ? ST_IDLE : ST_WAIT_DATA;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign w_hs    = wvalid_c & m00_axi.wready;
    assign advance = (state == ST_B) && m00_axi.bvalid && last_burst;

    // Frame progress, burst descriptor and status flags
    always_ff @(posedge m00_axi_aclk or posedge m00_axi_asy_rst) begin
        if (m00_axi_asy_rst) begin
            remaining    <= '0;
            offset       <= '0;
            beat_cnt     <= '0;
            awaddr_q     <= BASE_ADDR;
            awlen_q      <= 8'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            wr_error_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (frame_start && state != ST_IDLE) overrun_q <= 1'b1;
            case (state)
                ST_IDLE: if (frame_start) begin
                    remaining <= CW'(FRAME_WORDS);
                    offset    <= '0;
                    busy_q    <= 1'b1;
                end
                ST_WAIT_DATA: if (data_ready) begin
                    awaddr_q <= buf_base + ADDR_WIDTH'(offset) * BYTES_PER_WORD;
                    awlen_q  <= 8'(beats - BW'(1));
                    beat_cnt <= '0;
                end
                ST_W: if (w_hs) beat_cnt <= beat_cnt + BW'(1);
                ST_B: if (m00_axi.bvalid) begin
                    if (m00_axi.bresp != RESP_OKAY) wr_error_q <= 1'b1;
                    remaining <= remaining - CW'(beats);
                    offset    <= offset + CW'(beats);
                    if (last_burst) begin
                        busy_q       <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    cam_buf_ring #(
        .ADDR_WIDTH    (ADDR_WIDTH),
        .BASE_ADDR     (BASE_ADDR),
        .BUF_STRIDE    (BUF_STRIDE),
        .NUM_FRAME_BUF (NUM_FRAME_BUF)
    ) u_buf_ring (
        .clk          (m00_axi_aclk),
        .rst          (m00_axi_asy_rst),
        .advance      (advance),
`ifdef CAM_BUF_LOCK_EN
        .rd_lock_valid(rd_lock_valid),
        .rd_lock_idx  (rd_lock_idx),
`endif
        .buf_idx      (buf_idx),
        .last_buf_idx (last_buf_idx),
        .buf_base     (buf_base)
    );

    assign m00_axi.awaddr  = awaddr_q;
    assign m00_axi.awlen   = awlen_q;
    assign m00_axi.awsize  = axi_size(DATA_WIDTH);
    assign m00_axi.awburst = BURST_INCR;
    assign m00_axi.awvalid = awvalid_c;
    assign m00_axi.wdata   = fifo_dout;
    assign m00_axi.wstrb   = '1;
    assign m00_axi.wlast   = (state == ST_W) && last_beat;
    assign m00_axi.wvalid  = wvalid_c;
    assign m00_axi.bready  = bready_c;
    assign fifo_rd_en      = w_hs;
    assign frame_done      = frame_done_q;
    assign busy            = busy_q;
    assign wr_error        = wr_error_q;
    assign frame_overrun   = overrun_q;

endmodule

// File: tb/tb_cam_frame_wr_ctrl.sv
// Self-checking bench for cam_frame_wr_ctrl: FIFO/AXI-slave model with random
// backpressure, expected bursts planned from frame size, burst length and buffer ring.
module tb_cam_frame_wr_ctrl;

    localparam int          ADDR_WIDTH    = 32;
    localparam int          DATA_WIDTH    = 32;
    localparam int          CNT_WIDTH     = 11;
    localparam logic [31:0] BASE_ADDR     = 32'h1000_0000;
    localparam logic [31:0] BUF_STRIDE    = 32'h0010_0000;
    localparam int          NUM_FRAME_BUF = 3;
    localparam int          FRAME_WORDS   = 300;
    localparam int          BURST_LEN     = 128;
    localparam int          BURSTS_PER_FRAME = (FRAME_WORDS + BURST_LEN - 1) / BURST_LEN;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  frame_start;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_empty;
    logic [CNT_WIDTH-1:0]  fifo_rd_data_count;
    logic                  fifo_rd_en;
    logic                  frame_done;
    logic [2:0]            last_buf_idx;
    logic                  busy, wr_error, frame_overrun;
`ifdef CAM_BUF_LOCK_EN
    logic                  rd_lock_valid;
    logic [2:0]            rd_lock_idx;
`endif

    always #5 clk = ~clk;

    cam_frame_wr_ctrl_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) axi ();

    cam_frame_wr_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH),
        .BASE_ADDR(BASE_ADDR), .BUF_STRIDE(BUF_STRIDE),
        .NUM_FRAME_BUF(NUM_FRAME_BUF), .FRAME_WORDS(FRAME_WORDS),
        .BURST_LEN(BURST_LEN), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .m00_axi_aclk      (clk),
        .m00_axi_asy_rst   (rst),
        .frame_start       (frame_start),
        .fifo_dout         (fifo_dout),
        .fifo_empty        (fifo_empty),
        .fifo_rd_data_count(fifo_rd_data_count),
        .fifo_rd_en        (fifo_rd_en),
`ifdef CAM_BUF_LOCK_EN
        .rd_lock_valid     (rd_lock_valid),
        .rd_lock_idx       (rd_lock_idx),
`endif
        .m00_axi           (axi),
        .frame_done        (frame_done),
        .last_buf_idx      (last_buf_idx),
        .busy              (busy),
        .wr_error          (wr_error),
        .frame_overrun     (frame_overrun)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } burst_t;

    int          checks, errors;
    int unsigned fifo_q[$];
    int unsigned push_val, exp_wdata;
    burst_t      exp_aw[$];
    burst_t      cur;
    bit          w_open, done_due, model_busy, exp_err, exp_ovr;
    int          beat, pending_b, b_seen, frame_bursts, frames_done;
    int          model_buf, cur_frame_buf, exp_last, err_burst;
    int          push_pct, ready_pct;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_buf(input int b);
        int n;
        n = (b + 1) % NUM_FRAME_BUF;
`ifdef CAM_BUF_LOCK_EN
        if (NUM_FRAME_BUF > 1 && rd_lock_valid && n == int'(rd_lock_idx))
            n = (n + 1) % NUM_FRAME_BUF;
`endif
        return n;
    endfunction

    // Plan every burst of a new frame from frame size, burst length and target buffer
    task automatic start_frame_model();
        burst_t b;
        int     n;
        cur_frame_buf = model_buf;
        for (int o = 0; o < FRAME_WORDS; o += BURST_LEN) begin
            n      = (FRAME_WORDS - o < BURST_LEN) ? FRAME_WORDS - o : BURST_LEN;
            b.addr = BASE_ADDR + 32'(model_buf) * BUF_STRIDE + 32'(o * (DATA_WIDTH / 8));
            b.len  = 8'(n - 1);
            exp_aw.push_back(b);
        end
        model_busy = 1'b1;
    endtask

    // Observe the values the DUT presents to the coming rising edge
    task automatic monitor();
        if (frame_done || done_due) check("frame_done", frame_done, done_due);
        done_due = 1'b0;
        if (fifo_rd_en || (axi.wvalid && axi.wready))
            check("fifo_rd_en", fifo_rd_en, axi.wvalid && axi.wready);
        if (axi.awvalid) begin
            if (exp_aw.size() == 0) check("aw_unexpected", axi.awvalid, 1'b0);
            else begin
                check("awaddr", axi.awaddr, exp_aw[0].addr);
                check("awlen", axi.awlen, exp_aw[0].len);
                check("aw_one_outstanding", w_open || pending_b != 0, 1'b0);
                check("aw_fifo_level", 32'(fifo_rd_data_count) > 32'(axi.awlen), 1'b1);
                if (axi.awready) begin
                    cur    = exp_aw.pop_front();
                    w_open = 1'b1;
                    beat   = 0;
                end
            end
        end
        if (axi.wvalid) begin
            check("w_fifo_nonempty", fifo_empty, 1'b0);
            check("w_after_aw", w_open, 1'b1);
            if (axi.wready && w_open) begin
                check("wdata", axi.wdata, exp_wdata);
                check("wlast", axi.wlast, beat == int'(cur.len));
                exp_wdata++;
                if (fifo_q.size() > 0) void'(fifo_q.pop_front());
                beat++;
                if (beat > int'(cur.len)) begin
                    w_open = 1'b0;
                    pending_b++;
                end
            end
        end
        if (axi.bvalid && axi.bready) begin
            pending_b--;
            if (axi.bresp != 2'b00) exp_err = 1'b1;
            b_seen++;
            frame_bursts++;
            if (frame_bursts == BURSTS_PER_FRAME) begin
                frame_bursts = 0;
                done_due     = 1'b1;
                frames_done++;
                exp_last     = cur_frame_buf;
                model_buf    = next_buf(cur_frame_buf);
                model_busy   = 1'b0;
            end
        end
    endtask

    // One clock: drive new inputs on the falling edge, then check
    task automatic cycle(input bit fs);
        @(negedge clk);
        frame_start = fs;
        if (fs) begin
            if (model_busy) exp_ovr = 1'b1;
            else            start_frame_model();
        end
        if (fifo_q.size() < 1500 && $urandom_range(99) < push_pct) begin
            fifo_q.push_back(push_val);
            push_val++;
        end
        axi.awready        = ($urandom_range(99) < ready_pct);
        axi.wready         = ($urandom_range(99) < ready_pct);
        axi.bvalid         = (pending_b > 0) && ($urandom_range(99) < ready_pct);
        axi.bresp          = (b_seen == err_burst) ? 2'b10 : 2'b00;
        fifo_empty         = (fifo_q.size() == 0);
        fifo_dout          = fifo_empty ? '0 : fifo_q[0];
        fifo_rd_data_count = (fifo_q.size() > 2047) ? 11'd2047 : 11'(fifo_q.size());
        #1;
        monitor();
    endtask

    task automatic wait_frames(input int target, input int budget);
        for (int i = 0; i < budget && frames_done < target; i++) cycle(1'b0);
        check("frame_timeout", frames_done >= target, 1'b1);
    endtask

    initial begin
        int target;
        checks = 0; errors = 0;
        rst = 1'b1; frame_start = 1'b0;
        fifo_empty = 1'b1; fifo_dout = '0; fifo_rd_data_count = '0;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
`ifdef CAM_BUF_LOCK_EN
        rd_lock_valid = 1'b1; rd_lock_idx = 3'd1;
`endif
        push_val = 32'hA000_0000; exp_wdata = push_val;
        w_open = 0; done_due = 0; model_busy = 0; exp_err = 0; exp_ovr = 0;
        beat = 0; pending_b = 0; b_seen = 0; frame_bursts = 0; frames_done = 0;
        model_buf = 0; cur_frame_buf = 0; exp_last = NUM_FRAME_BUF - 1; err_burst = -1;
        push_pct = 0; ready_pct = 100;

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_awvalid", axi.awvalid, 1'b0);
        check("rst_wvalid", axi.wvalid, 1'b0);
        check("rst_bready", axi.bready, 1'b0);
        check("rst_fifo_rd_en", fifo_rd_en, 1'b0);
        check("rst_frame_done", frame_done, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_error", wr_error, 1'b0);
        check("rst_overrun", frame_overrun, 1'b0);
        check("rst_awaddr", axi.awaddr, 32'h1000_0000);
        check("rst_awlen", axi.awlen, 8'd0);
        check("rst_last_buf", last_buf_idx, 3'd2);
        check("wstrb", axi.wstrb, 4'hF);
        check("awsize", axi.awsize, 3'd2);
        check("awburst", axi.awburst, 2'b01);
        rst = 1'b0;

        // Frame 1: FIFO preloaded, no backpressure; 2-cycle start latency
        for (int i = 0; i < FRAME_WORDS; i++) begin
            fifo_q.push_back(push_val);
            push_val++;
        end
        cycle(1'b1);
        check("lat_idle", axi.awvalid, 1'b0);
        cycle(1'b0);
        check("lat_wait", axi.awvalid, 1'b0);
        check("busy_f1", busy, 1'b1);
        cycle(1'b0);
        check("lat_aw", axi.awvalid, 1'b1);
        wait_frames(1, 2000);
        cycle(1'b0);
        check("last_buf_f1", last_buf_idx, 3'd0);
        check("busy_clr_f1", busy, 1'b0);
        check("bursts_left_f1", exp_aw.size(), 0);

        // Frame 2: FIFO filling slowly from empty, random backpressure
        push_pct = 30; ready_pct = 60;
        cycle(1'b1);
        cycle(1'b0);
        check("busy_f2", busy, 1'b1);
        wait_frames(2, 6000);
        cycle(1'b0);
        check("last_buf_f2", last_buf_idx, 3'(exp_last));

        // Frame 3: SLVERR on the second burst; frame still completes
        err_burst = b_seen + 1;
        cycle(1'b1);
        wait_frames(3, 6000);
        cycle(1'b0);
        check("wr_error_set", wr_error, 1'b1);
        check("wr_error_model", exp_err, 1'b1);
        check("last_buf_f3", last_buf_idx, 3'(exp_last));

        // Frame 4: wraps the ring; a stray frame_start mid-frame is flagged only
        push_pct = 60; ready_pct = 70;
        cycle(1'b1);
        repeat (60) cycle(1'b0);
        check("ovr_before", frame_overrun, 1'b0);
        cycle(1'b1);
        cycle(1'b0);
        check("ovr_set", frame_overrun, 1'b1);
        wait_frames(4, 6000);
        cycle(1'b0);
        check("last_buf_f4", last_buf_idx, 3'(exp_last));
        check("ovr_sticky", frame_overrun, exp_ovr);
        check("wr_error_sticky", wr_error, 1'b1);
        check("bursts_left_f4", exp_aw.size(), 0);

        // Frame 5: reset asserted mid-burst
        push_pct = 50; ready_pct = 100;
        cycle(1'b1);
        for (int i = 0; i < 3000 && !w_open; i++) cycle(1'b0);
        check("reached_w", w_open, 1'b1);
        repeat (3) cycle(1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_awvalid", axi.awvalid, 1'b0);
        check("arst_wvalid", axi.wvalid, 1'b0);
        check("arst_bready", axi.bready, 1'b0);
        check("arst_fifo_rd_en", fifo_rd_en, 1'b0);
        check("arst_busy", busy, 1'b0);
        exp_aw.delete();
        w_open = 0; pending_b = 0; frame_bursts = 0; done_due = 0;
        model_busy = 0; model_buf = 0; exp_err = 0; exp_ovr = 0;
        exp_last = NUM_FRAME_BUF - 1;
        exp_wdata = push_val - fifo_q.size();
        repeat (2) cycle(1'b0);
        rst = 1'b0;
        check("post_rst_awaddr", axi.awaddr, 32'h1000_0000);
        check("post_rst_last_buf", last_buf_idx, 3'd2);
        check("post_rst_wr_error", wr_error, 1'b0);
        check("post_rst_overrun", frame_overrun, 1'b0);

        // Frame 6: restarts from buffer 0
        ready_pct = 75;
        target = frames_done + 1;
        cycle(1'b1);
        wait_frames(target, 6000);
        cycle(1'b0);
        check("last_buf_f6", last_buf_idx, 3'd0);
        check("busy_clr_f6", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
